// File: rtl/cpu65xx_status_reg_pkg.sv
// cpu65xx_status_reg_pkg: microcode flag-update opcodes and P bit positions
package cpu65xx_status_reg_pkg;
  typedef enum logic [3:0] {
    STATUS_NOP  = 4'd0,
    STATUS_NZ   = 4'd1,
    STATUS_NZC  = 4'd2,
    STATUS_NVZC = 4'd3,
    STATUS_NVZ  = 4'd4,
    STATUS_Z    = 4'd5,
    STATUS_LOAD = 4'd6,
    STATUS_SET  = 4'd7,
    STATUS_CLR  = 4'd8
  } statusOp_e;
  localparam int C_BIT_IN_P = 0;
  localparam int Z_BIT_IN_P = 1;
  localparam int I_BIT_IN_P = 2;
  localparam int D_BIT_IN_P = 3;
  localparam int B_BIT_IN_P = 4;
  localparam int V_BIT_IN_P = 6;
  localparam int N_BIT_IN_P = 7;
  localparam logic [7:0] P_RESET_VALUE = 8'h34;
endpackage

// File: rtl/cpu65xx_so_edge_detect.sv
// cpu65xx_so_edge_detect: synchronizes an active-low pin and pulses once per falling edge
module cpu65xx_so_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pinN,
  output logic fallPulse
);
  logic [STAGES-1:0] syncFlops;
  logic prev;
  // flops reset high so releasing reset never looks like a falling edge
  always_ff @(posedge clk)
    if (!reset_n) begin
      syncFlops <= '1;
      prev <= 1'b1;
    end else begin
      syncFlops <= {syncFlops[STAGES-2:0], pinN};
      prev <= syncFlops[STAGES-1];
    end
  assign fallPulse = prev & ~syncFlops[STAGES-1];
endmodule

// File: rtl/cpu65xx_status_reg.sv
// cpu65xx_status_reg: 65xx processor status register with SO pin and interrupt side effects
module cpu65xx_status_reg
  import cpu65xx_status_reg_pkg::*;
#(
  parameter bit CMOS_CLEAR_D = 1'b1,
  parameter bit SO_ENABLE = 1'b1,
  parameter int SO_SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] statusOp,
  input  logic [2:0] flagSel,
  input  logic       aluCarry,
  input  logic       aluZero,
  input  logic       aluNegative,
  input  logic       aluOverflow,
  input  logic [7:0] dataIn,
  input  logic       soPinN,
  input  logic       interruptEntry,
  input  logic       instructionBoundary,
  input  logic       pushBreak,
  output logic [7:0] pReg,
  output logic [7:0] pushValue,
  output logic       carry,
  output logic       overflow,
  output logic       decimalMode,
  output logic       irqMask
);
  logic [7:0] p, pNext;
  logic soSet;
  logic selValid;

  generate
    if (SO_ENABLE) begin : g_so
      cpu65xx_so_edge_detect #(.STAGES(SO_SYNC_STAGES)) u_soEdge (
        .clk(clk),
        .reset_n(reset_n),
        .pinN(soPinN),
        .fallPulse(soSet)
      );
    end else begin : g_noSo
      assign soSet = 1'b0;
    end
  endgenerate

  assign selValid = (flagSel != 3'd4) && (flagSel != 3'd5);

  // next P: microcode op first, then SO and interrupt entry override their flags
  always_comb begin
    pNext = p;
    case (statusOp)
      STATUS_NZ: {pNext[N_BIT_IN_P], pNext[Z_BIT_IN_P]} = {aluNegative, aluZero};
      STATUS_NZC: {pNext[N_BIT_IN_P], pNext[Z_BIT_IN_P], pNext[C_BIT_IN_P]} = {aluNegative, aluZero, aluCarry};
      STATUS_NVZC: {pNext[N_BIT_IN_P], pNext[V_BIT_IN_P], pNext[Z_BIT_IN_P], pNext[C_BIT_IN_P]} = {aluNegative, aluOverflow, aluZero, aluCarry};
      STATUS_NVZ: {pNext[N_BIT_IN_P], pNext[V_BIT_IN_P], pNext[Z_BIT_IN_P]} = {aluNegative, aluOverflow, aluZero};
      STATUS_Z: pNext[Z_BIT_IN_P] = aluZero;
      STATUS_LOAD: pNext = dataIn;
      STATUS_SET: if (selValid) pNext[flagSel] = 1'b1;
      STATUS_CLR: if (selValid) pNext[flagSel] = 1'b0;
      default: pNext = p;
    endcase
    pNext[5] = 1'b1;
    pNext[B_BIT_IN_P] = 1'b1;
    if (soSet) pNext[V_BIT_IN_P] = 1'b1;
    if (interruptEntry) pNext[I_BIT_IN_P] = 1'b1;
    if (interruptEntry && CMOS_CLEAR_D) pNext[D_BIT_IN_P] = 1'b0;
  end

  // P update; irqMask samples the pre-update I only at instruction boundaries
  always_ff @(posedge clk)
    if (!reset_n) begin
      p <= P_RESET_VALUE;
      irqMask <= 1'b1;
    end else begin
      p <= pNext;
      if (instructionBoundary) irqMask <= p[I_BIT_IN_P];
    end

  assign pReg = p;
  assign pushValue = {p[7:6], 1'b1, pushBreak, p[3:0]};
  assign carry = p[C_BIT_IN_P];
  assign overflow = p[V_BIT_IN_P];
  assign decimalMode = p[D_BIT_IN_P];
endmodule

// File: tb/tb_cpu65xx_status_reg.sv
// tb_cpu65xx_status_reg: directed self-checking bench for the status register
module tb_cpu65xx_status_reg;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] statusOp = 4'd0;
  logic [2:0] flagSel = 3'd0;
  logic aluCarry = 1'b0, aluZero = 1'b0, aluNegative = 1'b0, aluOverflow = 1'b0;
  logic [7:0] dataIn = 8'h00;
  logic soPinN = 1'b1;
  logic interruptEntry = 1'b0;
  logic instructionBoundary = 1'b0;
  logic pushBreak = 1'b1;
  logic [7:0] pReg, pushValue;
  logic carry, overflow, decimalMode, irqMask;
  int total = 0;
  int bad = 0;

  cpu65xx_status_reg dut (
    .clk(clk), .reset_n(reset_n), .statusOp(statusOp), .flagSel(flagSel),
    .aluCarry(aluCarry), .aluZero(aluZero), .aluNegative(aluNegative), .aluOverflow(aluOverflow),
    .dataIn(dataIn), .soPinN(soPinN), .interruptEntry(interruptEntry),
    .instructionBoundary(instructionBoundary), .pushBreak(pushBreak),
    .pReg(pReg), .pushValue(pushValue), .carry(carry), .overflow(overflow),
    .decimalMode(decimalMode), .irqMask(irqMask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic op(input logic [3:0] o, input logic [2:0] f);
    statusOp = o;
    flagSel = f;
    tick();
    statusOp = 4'd0;
  endtask

  initial begin
    tick();
    tick();
    check("rst_p", pReg, 8'h34);
    check("rst_irq", {7'd0, irqMask}, 8'd1);
    check("rst_d", {7'd0, decimalMode}, 8'd0);
    check("rst_c", {7'd0, carry}, 8'd0);
    check("rst_v", {7'd0, overflow}, 8'd0);
    check("rst_push_b1", pushValue, 8'h34);
    pushBreak = 1'b0;
    #1;
    check("rst_push_b0", pushValue, 8'h24);
    reset_n = 1'b1;
    tick();
    check("post_rst_p", pReg, 8'h34);
    {aluNegative, aluOverflow, aluZero, aluCarry} = 4'b1101;
    op(4'd3, 3'd0);
    check("nvzc_p", pReg, 8'hF5);
    check("nvzc_c", {7'd0, carry}, 8'd1);
    check("nvzc_v", {7'd0, overflow}, 8'd1);
    {aluNegative, aluOverflow, aluZero, aluCarry} = 4'b0010;
    op(4'd1, 3'd0);
    check("nz_p", pReg, 8'h77);
    dataIn = 8'h0B;
    op(4'd6, 3'd0);
    check("load_p", pReg, 8'h3B);
    check("load_d", {7'd0, decimalMode}, 8'd1);
    interruptEntry = 1'b1;
    op(4'd6, 3'd0);
    interruptEntry = 1'b0;
    check("load_irq_p", pReg, 8'h37);
    check("load_irq_d", {7'd0, decimalMode}, 8'd0);
    op(4'd8, 3'd2);
    check("cli_p", pReg, 8'h33);
    check("cli_irq_held", {7'd0, irqMask}, 8'd1);
    op(4'd7, 3'd2);
    check("sei_p", pReg, 8'h37);
    instructionBoundary = 1'b1;
    op(4'd8, 3'd2);
    check("cli_bnd_p", pReg, 8'h33);
    check("bnd1_irq", {7'd0, irqMask}, 8'd1);
    op(4'd0, 3'd0);
    check("bnd2_irq", {7'd0, irqMask}, 8'd0);
    instructionBoundary = 1'b0;
    interruptEntry = 1'b1;
    op(4'd8, 3'd2);
    interruptEntry = 1'b0;
    check("irq_beats_clr", pReg, 8'h37);
    op(4'd8, 3'd2);
    check("cli_again", pReg, 8'h33);
    soPinN = 1'b0;
    tick();
    check("so_e1", {7'd0, overflow}, 8'd0);
    tick();
    check("so_e2", {7'd0, overflow}, 8'd0);
    tick();
    check("so_e3", {7'd0, overflow}, 8'd1);
    op(4'd8, 3'd6);
    check("so_clrv", {7'd0, overflow}, 8'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("so_held_low", {7'd0, overflow}, 8'd0);
    end
    soPinN = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("so_release", pReg, 8'h33);
    soPinN = 1'b0;
    tick();
    tick();
    op(4'd8, 3'd6);
    check("so_beats_clrv", pReg, 8'h73);
    op(4'd8, 3'd6);
    check("clrv_after_so", pReg, 8'h33);
    {aluNegative, aluOverflow, aluZero, aluCarry} = 4'b1111;
    for (int o = 9; o < 16; o++) begin
      op(4'(o), 3'd7);
      check("op_hi_nop", pReg, 8'h33);
    end
    op(4'd7, 3'd4);
    check("set_b_nop", pReg, 8'h33);
    op(4'd8, 3'd5);
    check("clr_5_nop", pReg, 8'h33);
    aluZero = 1'b0;
    op(4'd5, 3'd0);
    check("z_only", pReg, 8'h31);
    {aluNegative, aluOverflow, aluZero, aluCarry} = 4'b1110;
    op(4'd4, 3'd0);
    check("nvz", pReg, 8'hF3);
    {aluNegative, aluOverflow, aluZero, aluCarry} = 4'b0000;
    op(4'd2, 3'd0);
    check("nzc", pReg, 8'h70);
    op(4'd7, 3'd3);
    check("sed_p", pReg, 8'h78);
    check("sed_d", {7'd0, decimalMode}, 8'd1);
    pushBreak = 1'b1;
    #1;
    check("push_b1", pushValue, 8'h78);
    pushBreak = 1'b0;
    #1;
    check("push_b0", pushValue, 8'h68);
    reset_n = 1'b0;
    soPinN = 1'b1;
    dataIn = 8'hCF;
    op(4'd6, 3'd0);
    check("midrst_p", pReg, 8'h34);
    check("midrst_irq", {7'd0, irqMask}, 8'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
